alarm_controller: RTL and testbench

Sequencing controller for the alarm audio/LED player. It watches the time-match and alarm-enable inputs and owns the player's `player_en` line, which restarts the melody and LED pattern on every assertion. It decodes snooze and stop button presses, limits the number of snoozes, and times out an unanswered alarm. It sits between the clock/compare logic and `alarm_player`.

---
 rtl/alarm_controller.sv | 152 +++++++++++++++
 tb/tb_alarm_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm sequencing controller: owns player_en, decodes snooze/stop presses,
// limits snoozes and times out ringing and snoozing with a seconds timer.
module alarm_controller #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_on,
  input  logic       alarm_match,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       player_en,
  output logic       snoozing,
  output logic [3:0] snooze_left,
  output logic [1:0] state
);

  localparam int SEC_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW      = $clog2(SEC_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] RING_LOAD   = SW'(RING_TIMEOUT_S);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_S);
  localparam logic [3:0]    SNOOZE_INIT = 4'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          cur_state;
  state_t          next_state;
  logic [3:0]      next_left;
  logic [PW-1:0]   presc;
  logic [SW-1:0]   sec_left;
  logic            snooze_q;
  logic            stop_q;
  logic            snooze_rise;
  logic            stop_rise;
  logic            running;
  logic            tick;
  logic            expiry;
  logic            changing;

  assign snooze_rise = snooze_btn & ~snooze_q;
  assign stop_rise   = stop_btn & ~stop_q;
  assign running     = (cur_state == RINGING) || (cur_state == SNOOZE);
  assign tick        = running && (presc == PRESC_LAST);
  assign expiry      = tick && (sec_left == SW'(1));
  assign changing    = (next_state != cur_state);
  assign state       = cur_state;

  // Next-state and snooze budget; an ignored snooze press behaves as no press.
  always_comb begin
    next_state = cur_state;
    next_left  = snooze_left;
    case (cur_state)
      IDLE: begin
        if (alarm_on && alarm_match) begin
          next_state = RINGING;
          next_left  = SNOOZE_INIT;
        end else begin
          next_state = IDLE;
        end
      end
      RINGING: begin
        if (!alarm_on) begin
          next_state = IDLE;
        end else if (stop_rise) begin
          next_state = DONE;
        end else if (snooze_rise && (snooze_left != 4'd0)) begin
          next_state = SNOOZE;
          next_left  = snooze_left - 4'd1;
        end else if (expiry) begin
          next_state = DONE;
        end else begin
          next_state = RINGING;
        end
      end
      SNOOZE: begin
        if (!alarm_on) begin
          next_state = IDLE;
        end else if (stop_rise) begin
          next_state = DONE;
        end else if (expiry) begin
          next_state = RINGING;
        end else begin
          next_state = SNOOZE;
        end
      end
      DONE: begin
        if (!alarm_match || !alarm_on) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, button history and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= IDLE;
      snooze_left <= 4'd0;
      snooze_q    <= 1'b1;
      stop_q      <= 1'b1;
      player_en   <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      cur_state   <= next_state;
      snooze_left <= next_left;
      snooze_q    <= snooze_btn;
      stop_q      <= stop_btn;
      player_en   <= (next_state == RINGING);
      snoozing    <= (next_state == SNOOZE);
    end
  end

  // Prescaler restarts on every transition so each visit gets whole seconds.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sec_left <= '0;
    end else begin
      if (changing || tick || !running) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (changing && (next_state == RINGING)) begin
        sec_left <= RING_LOAD;
      end else if (changing && (next_state == SNOOZE)) begin
        sec_left <= SNOOZE_LOAD;
      end else if (tick) begin
        sec_left <= sec_left - SW'(1);
      end else begin
        sec_left <= sec_left;
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller with CLK_HZ=10, RING=3 s, SNOOZE=2 s, MAX_SNOOZES=2.
module tb_alarm_controller;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alarm_on = 1'b0;
  logic       alarm_match = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       player_en;
  logic       snoozing;
  logic [3:0] snooze_left;
  logic [1:0] state;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] e;
  logic [7:0] obs;

  always #5 clk = ~clk;

  alarm_controller #(
    .CLK_HZ(10), .RING_TIMEOUT_S(3), .SNOOZE_S(2), .MAX_SNOOZES(2)
  ) dut (
    .clk(clk), .rst(rst), .alarm_on(alarm_on), .alarm_match(alarm_match),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn), .player_en(player_en),
    .snoozing(snoozing), .snooze_left(snooze_left), .state(state)
  );

  assign obs = {state, player_en, snoozing, snooze_left};

  // Expected output vector {state, player_en, snoozing, snooze_left}.
  function automatic logic [7:0] expv(input logic [1:0] st, input logic [3:0] left);
    return {st, (st == S_RING), (st == S_SNZ), left};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; snooze_btn = 1'b1;
    sb.push_back(expv(S_IDLE, 4'd0));
    repeat (3) step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold got=%h expected=%h", obs, e); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(expv(S_IDLE, 4'd0)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release[%0d] got=%h expected=%h", i, obs, e); end
    end
  endtask

  task automatic test_timeout();
    alarm_on = 1'b1; alarm_match = 1'b1;
    for (int i = 0; i < 34; i++) begin
      sb.push_back(expv((i < 30) ? S_RING : S_DONE, 4'd2)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout[%0d] got=%h expected=%h", i, obs, e); end
    end
    alarm_match = 1'b0; snooze_btn = 1'b0;
    sb.push_back(expv(S_IDLE, 4'd2)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL timeout_idle got=%h expected=%h", obs, e); end
  endtask

  task automatic test_snooze_limit();
    alarm_match = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(expv(S_RING, 4'd2)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL limit_ring[%0d] got=%h expected=%h", i, obs, e); end
    end
    // First snooze; alarm_match falls mid-snooze with no effect.
    snooze_btn = 1'b1;
    for (int i = 0; i < 21; i++) begin
      sb.push_back(expv((i < 20) ? S_SNZ : S_RING, 4'd1)); step();
      snooze_btn = 1'b0;
      if (i == 5) alarm_match = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL snooze1[%0d] got=%h expected=%h", i, obs, e); end
    end
    snooze_btn = 1'b1;
    for (int i = 0; i < 21; i++) begin
      sb.push_back(expv((i < 20) ? S_SNZ : S_RING, 4'd0)); step();
      snooze_btn = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL snooze2[%0d] got=%h expected=%h", i, obs, e); end
    end
    // Third press is ignored; the ring times out, then DONE leaves as match is low.
    for (int j = 1; j < 32; j++) begin
      snooze_btn = (j == 3);
      sb.push_back(expv((j < 30) ? S_RING : ((j == 30) ? S_DONE : S_IDLE), 4'd0)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL snooze3[%0d] got=%h expected=%h", j, obs, e); end
    end
    snooze_btn = 1'b0;
  endtask

  task automatic test_back_to_back();
    alarm_match = 1'b1;
    sb.push_back(expv(S_RING, 4'd2)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL held_start got=%h expected=%h", obs, e); end
    snooze_btn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sb.push_back(expv((i < 20) ? S_SNZ : ((i < 50) ? S_RING : S_DONE), 4'd1)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL held[%0d] got=%h expected=%h", i, obs, e); end
    end
    snooze_btn = 1'b0; alarm_match = 1'b0;
    sb.push_back(expv(S_IDLE, 4'd1)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL held_idle got=%h expected=%h", obs, e); end
    alarm_match = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(expv(S_RING, 4'd2)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL simul_ring[%0d] got=%h expected=%h", i, obs, e); end
    end
    stop_btn = 1'b1; snooze_btn = 1'b1;
    sb.push_back(expv(S_DONE, 4'd2)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL simul_press got=%h expected=%h", obs, e); end
    stop_btn = 1'b0; snooze_btn = 1'b0; alarm_match = 1'b0;
    sb.push_back(expv(S_IDLE, 4'd2)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL simul_idle got=%h expected=%h", obs, e); end
  endtask

  task automatic test_disable_reset();
    alarm_match = 1'b1;
    sb.push_back(expv(S_RING, 4'd2)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL dis_ring got=%h expected=%h", obs, e); end
    snooze_btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(expv(S_SNZ, 4'd1)); step();
      snooze_btn = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL dis_snooze[%0d] got=%h expected=%h", i, obs, e); end
    end
    alarm_on = 1'b0;
    sb.push_back(expv(S_IDLE, 4'd1)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL dis_off got=%h expected=%h", obs, e); end
    alarm_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(expv(S_RING, 4'd2)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_ring[%0d] got=%h expected=%h", i, obs, e); end
    end
    rst = 1'b1;
    sb.push_back(expv(S_IDLE, 4'd0)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_midring got=%h expected=%h", obs, e); end
    rst = 1'b0; alarm_on = 1'b0; alarm_match = 1'b0;
    sb.push_back(expv(S_IDLE, 4'd0)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_after got=%h expected=%h", obs, e); end
  endtask

  task automatic test_timer_restart();
    alarm_on = 1'b1; alarm_match = 1'b1;
    // Ring cycles 0..18; the press is sampled in cycle 18, one cycle before a tick.
    for (int j = 0; j < 19; j++) begin
      sb.push_back(expv(S_RING, 4'd2)); step();
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL restart_ring[%0d] got=%h expected=%h", j, obs, e); end
    end
    snooze_btn = 1'b1;
    for (int i = 0; i < 21; i++) begin
      sb.push_back(expv((i < 20) ? S_SNZ : S_RING, 4'd1)); step();
      snooze_btn = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL restart_snooze[%0d] got=%h expected=%h", i, obs, e); end
    end
    stop_btn = 1'b1;
    sb.push_back(expv(S_DONE, 4'd1)); step();
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL restart_stop got=%h expected=%h", obs, e); end
    stop_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_snooze_limit();
    test_back_to_back();
    test_disable_reset();
    test_timer_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
